// File: rtl/vip_ctrl_pkg.sv
// vip_ctrl_pkg: shared constants, beat-count helpers and FSM state type for the control packet sender
// Contents: CTRL_PKT_TYPE header code, per-BITWIDTH payload beat counts (32/24/8 -> 3/3/9),
//           nibble slots per beat, and the state_e enum.
package vip_ctrl_pkg;
  localparam logic [3:0] CTRL_PKT_TYPE = 4'hF;
  localparam int BEATS_32 = 3;
  localparam int BEATS_24 = 3;
  localparam int BEATS_8 = 9;
  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_PAYLOAD} state_e;
  function automatic int payload_beats(input int bw);
    return bw == 8 ? BEATS_8 : bw == 24 ? BEATS_24 : BEATS_32;
  endfunction
  function automatic int nibble_slots(input int bw);
    return bw == 8 ? 1 : bw == 24 ? 3 : 4;
  endfunction
endpackage

// File: rtl/control_nibble_pack.sv
// control_nibble_pack: maps a payload beat index and captured fields to one beat of packet data
// Ports: idx (payload beat index), width/height/interlace (captured fields), data (beat payload).
// The fields form a 9-nibble stream W[15:12]..H[3:0],I; each beat carries the next SLOTS nibbles,
// slot s landing in data[8s+3:8s]. Every other bit is zero.
module control_nibble_pack
  import vip_ctrl_pkg::*;
#(
  parameter int BITWIDTH = 32
) (
  input  logic [3:0]          idx,
  input  logic [15:0]         width,
  input  logic [15:0]         height,
  input  logic [3:0]          interlace,
  output logic [BITWIDTH-1:0] data
);
  localparam int SLOTS = nibble_slots(BITWIDTH);
  logic [35:0] stream;
  assign stream = {width, height, interlace};
  always_comb begin
    data = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (int'(idx) * SLOTS + s < 9) data[8*s +: 4] = stream[35 - 4*(int'(idx) * SLOTS + s) -: 4];
    end
  end
endmodule

// File: rtl/control_out.sv
// control_out: sends one control packet (optional header + W/H/I nibble payload) per accepted request
// Ports: clk, rst (sync active-high); width/height/interlace + in_valid/in_ready request side;
//        source_data/valid/ready/sop/eop packet stream; busy while a packet is in flight.
// Build option: define CONTROL_OUT_HEADER_EN to prepend a header beat carrying CTRL_PKT_TYPE.
module control_out
  import vip_ctrl_pkg::*;
#(
  parameter int BITWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         width,
  input  logic [15:0]         height,
  input  logic [3:0]          interlace,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [BITWIDTH-1:0] source_data,
  output logic                source_valid,
  input  logic                source_ready,
  output logic                source_sop,
  output logic                source_eop,
  output logic                busy
);
  if (!(BITWIDTH == 8 || BITWIDTH == 24 || BITWIDTH == 32)) begin : g_bad_width
    $error("control_out: BITWIDTH must be 8, 24 or 32");
  end
`ifdef CONTROL_OUT_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam logic [3:0] LAST = 4'(payload_beats(BITWIDTH) + HDR - 1);
  state_e state_q, state_d;
  logic [3:0] beat_q, beat_d;
  logic [15:0] w_q, w_d, h_q, h_d;
  logic [3:0] i_q, i_d;
  logic [BITWIDTH-1:0] pack_data;
  logic take;
  assign in_ready = !rst && state_q == ST_IDLE;
  assign busy = state_q != ST_IDLE;
  assign source_valid = busy;
  assign source_sop = busy && beat_q == 4'd0;
  assign source_eop = busy && beat_q == LAST;
  assign take = source_valid && source_ready;
  // payload index skips the header beat when one is present
  control_nibble_pack #(.BITWIDTH(BITWIDTH)) u_pack (
    .idx      (beat_q - 4'(HDR)),
    .width    (w_q),
    .height   (h_q),
    .interlace(i_q),
    .data     (pack_data)
  );
  assign source_data = state_q == ST_HEADER ? BITWIDTH'(CTRL_PKT_TYPE) :
                       state_q == ST_PAYLOAD ? pack_data : '0;
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    w_d = w_q;
    h_d = h_q;
    i_d = i_q;
    if (in_valid && in_ready) begin
      state_d = HDR != 0 ? ST_HEADER : ST_PAYLOAD;
      beat_d = '0;
      w_d = width;
      h_d = height;
      i_d = interlace;
    end else if (take) begin
      state_d = beat_q == LAST ? ST_IDLE : ST_PAYLOAD;
      beat_d = beat_q == LAST ? 4'd0 : beat_q + 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q <= '0;
      w_q <= '0;
      h_q <= '0;
      i_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      w_q <= w_d;
      h_q <= h_d;
      i_q <= i_d;
    end
  end
endmodule

// File: tb/tb_control_out.sv
// tb_control_out: table-driven check of control_out at BITWIDTH 32, 24 and 8, plus stall and reset sequences
module tb_control_out;
`ifdef CONTROL_OUT_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  typedef struct {
    int u;
    logic [15:0] w;
    logic [15:0] h;
    logic [3:0] i;
    int n;
    logic [31:0] exp [9];
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] w_in, h_in;
  logic [3:0] i_in;
  logic vld [3];
  logic rdy [3];
  logic ir [3];
  logic sv [3];
  logic so [3];
  logic eo [3];
  logic bz [3];
  logic [31:0] dat [3];
  logic [31:0] d32;
  logic [23:0] d24;
  logic [7:0] d8;
  int n_chk = 0;
  int n_fail = 0;
  vec_t vec [5];
  always #5 clk = ~clk;
  assign dat[0] = d32;
  assign dat[1] = {8'h0, d24};
  assign dat[2] = {24'h0, d8};
  control_out #(.BITWIDTH(32)) d_32 (
    .clk(clk), .rst(rst), .width(w_in), .height(h_in), .interlace(i_in),
    .in_valid(vld[0]), .in_ready(ir[0]), .source_data(d32), .source_valid(sv[0]),
    .source_ready(rdy[0]), .source_sop(so[0]), .source_eop(eo[0]), .busy(bz[0]));
  control_out #(.BITWIDTH(24)) d_24 (
    .clk(clk), .rst(rst), .width(w_in), .height(h_in), .interlace(i_in),
    .in_valid(vld[1]), .in_ready(ir[1]), .source_data(d24), .source_valid(sv[1]),
    .source_ready(rdy[1]), .source_sop(so[1]), .source_eop(eo[1]), .busy(bz[1]));
  control_out #(.BITWIDTH(8)) d_8 (
    .clk(clk), .rst(rst), .width(w_in), .height(h_in), .interlace(i_in),
    .in_valid(vld[2]), .in_ready(ir[2]), .source_data(d8), .source_valid(sv[2]),
    .source_ready(rdy[2]), .source_sop(so[2]), .source_eop(eo[2]), .busy(bz[2]));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic vec_t mk(input int u, input logic [15:0] w, input logic [15:0] h,
                              input logic [3:0] i, input int n, input logic [31:0] e [9]);
    vec_t v;
    v.u = u;
    v.w = w;
    v.h = h;
    v.i = i;
    v.n = n;
    v.exp = e;
    return v;
  endfunction
  task automatic check_idle(input int u, input string tag);
    chk({tag, "_in_ready"}, 32'(ir[u]), 32'd1);
    chk({tag, "_valid"}, 32'(sv[u]), 32'd0);
    chk({tag, "_busy"}, 32'(bz[u]), 32'd0);
    chk({tag, "_eop"}, 32'(eo[u]), 32'd0);
    chk({tag, "_data"}, dat[u], 32'd0);
  endtask
  task automatic check_beat(input int u, input int b, input int nb, input logic [31:0] e);
    chk($sformatf("u%0d_b%0d_valid", u, b), 32'(sv[u]), 32'd1);
    chk($sformatf("u%0d_b%0d_data", u, b), dat[u], e);
    chk($sformatf("u%0d_b%0d_sop", u, b), 32'(so[u]), 32'(b == 0));
    chk($sformatf("u%0d_b%0d_eop", u, b), 32'(eo[u]), 32'(b == nb - 1));
    chk($sformatf("u%0d_b%0d_in_ready", u, b), 32'(ir[u]), 32'd0);
    chk($sformatf("u%0d_b%0d_busy", u, b), 32'(bz[u]), 32'd1);
  endtask
  task automatic run(input vec_t v, input int stall_at, input int stall_len, input int abort_at);
    int u;
    int nb;
    logic [31:0] e;
    u = v.u;
    nb = v.n + HDR;
    @(posedge clk);
    #1;
    w_in = v.w;
    h_in = v.h;
    i_in = v.i;
    vld[u] = 1'b1;
    rdy[u] = 1'b1;
    chk("req_in_ready", 32'(ir[u]), 32'd1);
    chk("req_no_valid_yet", 32'(sv[u]), 32'd0);
    @(posedge clk);
    #1;
    vld[u] = 1'b0;
    w_in = ~v.w;
    h_in = ~v.h;
    i_in = ~v.i;
    for (int b = 0; b < nb; b++) begin
      e = b < HDR ? 32'h0000000F : v.exp[b - HDR];
      check_beat(u, b, nb, e);
      if (b == abort_at) begin
        rst = 1'b1;
        #1;
        chk("rst_in_ready_low", 32'(ir[u]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_idle(u, "after_abort");
        chk("after_abort_sop", 32'(so[u]), 32'd0);
        return;
      end
      if (b == stall_at) begin
        rdy[u] = 1'b0;
        vld[u] = 1'b1;
        repeat (stall_len) begin
          @(posedge clk);
          #1;
          check_beat(u, b, nb, e);
        end
        vld[u] = 1'b0;
        rdy[u] = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    check_idle(u, "post_eop");
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      vld[k] = 1'b0;
      rdy[k] = 1'b1;
    end
    w_in = 16'h1111;
    h_in = 16'h2222;
    i_in = 4'h3;
    vec[0] = mk(0, 16'h0780, 16'h0438, 4'h3, 3,
                '{32'h00080700, 32'h08030400, 32'h00000003, 0, 0, 0, 0, 0, 0});
    vec[1] = mk(0, 16'hFFFF, 16'h0001, 4'hF, 3,
                '{32'h0F0F0F0F, 32'h01000000, 32'h0000000F, 0, 0, 0, 0, 0, 0});
    vec[2] = mk(2, 16'h1234, 16'h5678, 4'hA, 9,
                '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'hA});
    vec[3] = mk(1, 16'hABCD, 16'h1234, 4'h5, 3,
                '{32'h000C0B0A, 32'h0002010D, 32'h00050403, 0, 0, 0, 0, 0, 0});
    vec[4] = mk(2, 16'hFEDC, 16'hBA98, 4'h0, 9,
                '{32'hF, 32'hE, 32'hD, 32'hC, 32'hB, 32'hA, 32'h9, 32'h8, 32'h0});
    vld[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("rst_in_ready_u%0d", k), 32'(ir[k]), 32'd0);
    vld[0] = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_idle(k, $sformatf("reset_u%0d", k));
      chk($sformatf("reset_sop_u%0d", k), 32'(so[k]), 32'd0);
    end
    for (int k = 0; k < 5; k++) run(vec[k], -1, 0, -1);
    run(vec[0], HDR + 1, 5, -1);
    run(vec[2], HDR + 4, 3, -1);
    run(vec[0], -1, 0, HDR + 1);
    run(vec[0], -1, 0, -1);
    run(vec[3], -1, 0, HDR);
    run(vec[3], -1, 0, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
